mem_bus_arbiter: RTL



---
 rtl/mem_bus_arbiter.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Purpose: single-master scheduler sharing the external memory bus between fetch and NFU load/store ports.
// Latency: read done pulse MEM_LATENCY+1 cycles after the request cycle, write done 2 cycles after.
// Backpressure: requesters hold req until their done pulse; requests are only looked at in IDLE.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   fetchReq/fetchAddr           fetch read request and address
//   fetchData/fetchDone          fetch read data, valid with the one-cycle done pulse
//   fuReq/fuWrite/fuAddr/fuWData per-FU request, store flag, packed address and store data
//   fuRData/fuDone               shared FU load data, one-hot done pulse
//   addressBus/dataOut/enableWrite/dataIn   external memory bus
//   busy                         high whenever a transaction is in flight
module mem_bus_arbiter #(
  parameter int NFU                   = 2,
  parameter int PHYSICAL_ADDRESS_SIZE = 56,
  parameter int MEM_LATENCY           = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 fetchReq,
  input  logic [PHYSICAL_ADDRESS_SIZE-1:0]     fetchAddr,
  output logic [63:0]                          fetchData,
  output logic                                 fetchDone,
  input  logic [NFU-1:0]                       fuReq,
  input  logic [NFU-1:0]                       fuWrite,
  input  logic [NFU*PHYSICAL_ADDRESS_SIZE-1:0] fuAddr,
  input  logic [NFU*64-1:0]                    fuWData,
  output logic [63:0]                          fuRData,
  output logic [NFU-1:0]                       fuDone,
  output logic [PHYSICAL_ADDRESS_SIZE-1:0]     addressBus,
  output logic [63:0]                          dataOut,
  output logic                                 enableWrite,
  input  logic [63:0]                          dataIn,
  output logic                                 busy
);

  localparam int PAS = PHYSICAL_ADDRESS_SIZE;
  localparam int PW  = (NFU > 1) ? $clog2(NFU) : 1;
  localparam int CW  = (MEM_LATENCY > 2) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] rrPtr;
  logic [PW-1:0] grantFu;
  logic          grantIsFetch;
  logic          lastWasFetch;
  logic [CW-1:0] waitCnt;

  logic          fetchWins;
  logic          fuWins;
  logic [PW-1:0] fuPick;
  logic [PW-1:0] rrIdx;
  logic [NFU-1:0] grantOneHot;
  logic          readLast;
  logic          writeLast;

  // Round-robin search over FUs starting at rrPtr. Fetch normally wins, but
  // yields to any pending FU right after a fetch grant so FUs cannot starve.
  always_comb begin
    fuPick = rrPtr;
    fuWins = 1'b0;
    rrIdx  = '0;
    for (int i = 0; i < NFU; i++) begin
      if (int'(rrPtr) + i >= NFU) begin
        rrIdx = PW'(int'(rrPtr) + i - NFU);
      end else begin
        rrIdx = PW'(int'(rrPtr) + i);
      end
      if (!fuWins && fuReq[rrIdx]) begin
        fuWins = 1'b1;
        fuPick = rrIdx;
      end
    end
    fetchWins = fetchReq && !(lastWasFetch && (|fuReq));
  end

  always_comb begin
    grantOneHot = '0;
    for (int n = 0; n < NFU; n++) begin
      grantOneHot[n] = (grantFu == PW'(n));
    end
  end

  // Edge at which read data is captured: end of ADDR when the memory answers
  // in one cycle, otherwise the last WAIT cycle.
  assign readLast  = ((state == ADDR) && !enableWrite && (MEM_LATENCY == 1)) ||
                     ((state == WAIT) && (waitCnt == '0));
  assign writeLast = (state == ADDR) && enableWrite;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rrPtr        <= '0;
      grantFu      <= '0;
      grantIsFetch <= 1'b0;
      lastWasFetch <= 1'b0;
      waitCnt      <= '0;
      fetchData    <= '0;
      fetchDone    <= 1'b0;
      fuRData      <= '0;
      fuDone       <= '0;
      addressBus   <= '0;
      dataOut      <= '0;
      enableWrite  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      fetchDone <= 1'b0;
      fuDone    <= '0;

      if (readLast) begin
        if (grantIsFetch) begin
          fetchData <= dataIn;
          fetchDone <= 1'b1;
        end else begin
          fuRData <= dataIn;
          fuDone  <= grantOneHot;
        end
      end
      if (writeLast) begin
        fuDone <= grantOneHot;
      end

      case (state)
        IDLE: begin
          addressBus  <= '0;
          dataOut     <= '0;
          enableWrite <= 1'b0;
          if (fetchWins) begin
            grantIsFetch <= 1'b1;
            lastWasFetch <= 1'b1;
            addressBus   <= fetchAddr;
            state        <= ADDR;
            busy         <= 1'b1;
          end else if (fuWins) begin
            grantIsFetch <= 1'b0;
            grantFu      <= fuPick;
            lastWasFetch <= 1'b0;
            rrPtr        <= (fuPick == PW'(NFU - 1)) ? '0 : fuPick + 1'b1;
            addressBus   <= fuAddr[fuPick*PAS +: PAS];
            enableWrite  <= fuWrite[fuPick];
            dataOut      <= fuWrite[fuPick] ? fuWData[fuPick*64 +: 64] : '0;
            state        <= ADDR;
            busy         <= 1'b1;
          end
        end
        ADDR: begin
          // Store strobe and data are valid for the ADDR cycle only.
          enableWrite <= 1'b0;
          dataOut     <= '0;
          if (enableWrite || (MEM_LATENCY == 1)) begin
            state <= DONE;
          end else begin
            state   <= WAIT;
            waitCnt <= CW'(MEM_LATENCY - 2);
          end
        end
        WAIT: begin
          if (waitCnt == '0) begin
            state <= DONE;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        DONE: begin
          addressBus <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
